// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer for a bus-attached program/data memory.
// Grants one requester at a time and runs IDLE -> ACCESS -> ACK, three cycles per access.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NREQ   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        we,
   input  logic [NREQ*ADDR_W-1:0] addr,
   input  logic [NREQ*DATA_W-1:0] wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        ack,
   output logic [DATA_W-1:0]      rdata,
   output logic                   busy,
   output logic [ADDR_W-1:0]      mem_address,
   output logic                   mem_ie,
   output logic                   mem_oe,
   inout  wire  [DATA_W-1:0]      mem_bus
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StAck    = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [IDX_W-1:0]  last_grant_q;
   logic [IDX_W-1:0]  win_idx_q;
   logic              win_we_q;
   logic [ADDR_W-1:0] win_addr_q;
   logic [DATA_W-1:0] win_wdata_q;
   logic [DATA_W-1:0] rdata_q;

   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W-1:0]  cand;
   logic              drive_bus;

   logic [ADDR_W-1:0] addr_arr  [NREQ];
   logic [DATA_W-1:0] wdata_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
   end

   // Search starts one past the last winner, so a lone requester still wins at once.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IDX_W'((32'(last_grant_q) + k) % NREQ);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (pick_found) state_d = StAccess;
         StAccess: state_d = StAck;
         StAck:    state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= IDX_W'(NREQ - 1);
         win_idx_q    <= '0;
         win_we_q     <= 1'b0;
         win_addr_q   <= '0;
         win_wdata_q  <= '0;
         rdata_q      <= '0;
      end else begin
         state_q <= state_d;
         // Latch the whole request so later input changes cannot disturb the access.
         if (state_q == StIdle && pick_found) begin
            win_idx_q   <= pick_idx;
            win_we_q    <= we[pick_idx];
            win_addr_q  <= addr_arr[pick_idx];
            win_wdata_q <= wdata_arr[pick_idx];
         end
         if (state_q == StAccess && !win_we_q) begin
            rdata_q <= mem_bus;
         end
         if (state_q == StAck) begin
            last_grant_q <= win_idx_q;
         end
      end
   end

   always_comb begin
      gnt = '0;
      ack = '0;
      if (state_q == StAccess || state_q == StAck) begin
         gnt[win_idx_q] = 1'b1;
      end
      if (state_q == StAck) begin
         ack[win_idx_q] = 1'b1;
      end
   end

   assign drive_bus   = (state_q == StAccess) && win_we_q;
   assign mem_ie      = drive_bus;
   assign mem_oe      = (state_q == StAccess) && !win_we_q;
   // Address register only reloads on a grant, so it holds steady in IDLE and ACK.
   assign mem_address = win_addr_q;
   assign busy        = (state_q != StIdle);
   assign rdata       = rdata_q;
   assign mem_bus     = drive_bus ? win_wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level reference model
// and a simple falling-edge-write memory hanging off the bus.
module tb_mem_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 8;
   localparam int DW   = 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req, we, gnt, ack;
   logic [NREQ*AW-1:0]   addr;
   logic [NREQ*DW-1:0]   wdata;
   logic [DW-1:0]        rdata;
   logic                 busy;
   logic [AW-1:0]        mem_address;
   logic                 mem_ie, mem_oe;
   wire  [DW-1:0]        mem_bus;

   logic [DW-1:0]        mem [256];

   mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .NREQ   (NREQ)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .gnt         (gnt),
      .ack         (ack),
      .rdata       (rdata),
      .busy        (busy),
      .mem_address (mem_address),
      .mem_ie      (mem_ie),
      .mem_oe      (mem_oe),
      .mem_bus     (mem_bus)
   );

   always #5 clk = ~clk;

   // Memory: combinational read while oe, write on falling edge while ie.
   assign mem_bus = mem_oe ? mem[mem_address] : {DW{1'bz}};
   always @(negedge clk) if (mem_ie) mem[mem_address] <= mem_bus;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int          idx;
      bit          we;
      logic [7:0]  addr;
      logic [7:0]  bus;
      logic [7:0]  rdata;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state
   logic [7:0] ref_mem [256];
   int         model_lg;
   logic [7:0] model_rdata;

   // Round descriptor: r_n[i] = number of back-to-back accesses requester i holds req for
   int         r_n     [NREQ];
   bit         r_we    [NREQ];
   logic [7:0] r_addr  [NREQ];
   logic [7:0] r_wdata [NREQ];

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         chk("ie_oe_exclusive", 32'(mem_ie & mem_oe), 0);
         chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
         chk("ack_onehot0", 32'($onehot0(ack)), 1);
         if (mem_ie || mem_oe) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_access", 1, 0);
            end else begin
               e = exp_q[0];
               chk("access_gnt", gnt, 1 << e.idx);
               chk("access_ie", mem_ie, e.we);
               chk("access_oe", mem_oe, !e.we);
               chk("access_addr", mem_address, e.addr);
               chk("access_bus", mem_bus, e.bus);
               chk("access_ack_low", ack, 0);
               chk("access_busy", busy, 1);
            end
         end
         if (ack != 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_idx", ack, 1 << e.idx);
               chk("ack_gnt", gnt, 1 << e.idx);
               chk("ack_rdata", rdata, e.rdata);
               chk("ack_ie_oe_low", {mem_ie, mem_oe}, 0);
               chk("ack_busy", busy, 1);
            end
         end
      end
   end

   task automatic clear_round();
      for (int i = 0; i < NREQ; i++) begin
         r_n[i] = 0; r_we[i] = 1'b0; r_addr[i] = 8'h00; r_wdata[i] = 8'h00;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_mem_ie"}, mem_ie, 0);
      chk({tag, "_mem_oe"}, mem_oe, 0);
      chk({tag, "_mem_address"}, mem_address, 0);
      chk({tag, "_rdata"}, rdata, 0);
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 of the IDLE cycle after the
   // last ack.
   task automatic run_round(input string tag);
      int   left [NREQ];
      bit   drop [NREQ];
      int   total, rem, cyc, busy_cnt, last_ack_cyc, c;
      exp_t e;
      total = 0;
      for (int i = 0; i < NREQ; i++) begin
         left[i] = r_n[i]; total += r_n[i]; drop[i] = 1'b0;
      end
      // Serve order: round-robin over requesters that still want an access.
      for (int k = 0; k < total; k++) begin
         c = -1;
         for (int off = 1; off <= NREQ && c < 0; off++) begin
            if (left[(model_lg + off) % NREQ] > 0) c = (model_lg + off) % NREQ;
         end
         e.idx  = c;
         e.we   = r_we[c];
         e.addr = r_addr[c];
         if (r_we[c]) begin
            ref_mem[r_addr[c]] = r_wdata[c];
            e.bus = r_wdata[c];
         end else begin
            model_rdata = ref_mem[r_addr[c]];
            e.bus = model_rdata;
         end
         e.rdata = model_rdata;
         exp_q.push_back(e);
         left[c]--;
         model_lg = c;
      end
      for (int i = 0; i < NREQ; i++) begin
         req[i]            = (r_n[i] > 0);
         we[i]             = r_we[i];
         addr[i*AW +: AW]  = r_addr[i];
         wdata[i*DW +: DW] = r_wdata[i];
         left[i]           = r_n[i];
      end
      rem = total; cyc = 0; busy_cnt = 0; last_ack_cyc = 0;
      while (rem > 0 && cyc < 3 * total + 6) begin
         @(posedge clk); #1;
         cyc++;
         for (int i = 0; i < NREQ; i++) if (drop[i]) begin req[i] = 1'b0; drop[i] = 1'b0; end
         if (busy) busy_cnt++;
         for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
               left[i]--; rem--; last_ack_cyc = cyc;
               if (left[i] == 0) drop[i] = 1'b1;
            end
         end
      end
      chk({tag, "_done"}, rem, 0);
      chk({tag, "_latency"}, last_ack_cyc, 3 * total - 1);
      chk({tag, "_busy_cycles"}, busy_cnt, 2 * total);
      @(posedge clk); #1;
      req = '0;
      chk({tag, "_idle_after"}, busy, 0);
      if (rem != 0) exp_q.delete();
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'(i);
         ref_mem[i] = 8'(i);
      end
      req = '0; we = '0; addr = '0; wdata = '0;
      model_lg = NREQ - 1;
      model_rdata = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_idle", busy, 0);

      // Both requesters held for two reads each: grants 0,1,0,1
      clear_round();
      r_n[0] = 2; r_addr[0] = 8'h11;
      r_n[1] = 2; r_addr[1] = 8'h22;
      run_round("contend");

      clear_round();
      r_n[0] = 1; r_addr[0] = 8'h2A;
      run_round("read2a");
      chk("read2a_rdata", rdata, 8'h2A);

      clear_round();
      r_n[1] = 1; r_we[1] = 1'b1; r_addr[1] = 8'h10; r_wdata[1] = 8'hC3;
      run_round("write10");

      clear_round();
      r_n[0] = 1; r_addr[0] = 8'h10;
      run_round("readback10");
      chk("readback10_rdata", rdata, 8'hC3);

      clear_round();
      r_n[0] = 2; r_addr[0] = 8'h05;
      run_round("held05");
      chk("held05_rdata", rdata, 8'h05);

      for (int r = 0; r < 40; r++) begin
         clear_round();
         for (int i = 0; i < NREQ; i++) begin
            r_n[i]     = $urandom_range(0, 2);
            r_we[i]    = 1'($urandom_range(0, 1));
            r_addr[i]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            r_wdata[i] = 8'($urandom);
         end
         if (r_n[0] == 0 && r_n[1] == 0) r_n[$urandom_range(0, NREQ - 1)] = 1;
         run_round("rand");
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      // Abort a write in ACCESS before the falling edge
      req = '0; we = '0;
      req[1] = 1'b1; we[1] = 1'b1;
      addr[AW +: AW]  = 8'h33;
      wdata[DW +: DW] = ~ref_mem[8'h33];
      @(posedge clk); #1;
      chk("rst_access_ie", mem_ie, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_async");
      req = '0; we = '0;
      @(negedge clk); #1;
      chk("rst_mem_unchanged", mem[8'h33], ref_mem[8'h33]);
      @(negedge clk);
      rst_n = 1'b1;
      model_lg = NREQ - 1;
      model_rdata = 8'h00;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_no_ack", ack, 0);
      end

      // After reset requester 0 wins the tie again
      clear_round();
      r_n[0] = 1; r_addr[0] = 8'h33;
      r_n[1] = 1; r_addr[1] = 8'h2A;
      run_round("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing controller and round-robin arbiter for the 256x8 bus-attached program/data memory. It turns word-level read/write requests from NREQ requesters (CPU fetch/execute unit, program loader, …) into the memory's address/ie/oe/bus protocol. It is the sole owner of the memory's control pins and of its bus drive. It sits between the requesters and the memory, and grants exactly one access at a time.

## Interface
- ADDR_W, 8, address width; the memory is 2^ADDR_W words.
- DATA_W, 8, data word width.
- NREQ, 2, number of requesters (≥2). Index 0 is the CPU.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester access request, level.
- we  in  NREQ  per-requester write enable (1 = write, 0 = read); qualified by req.
- addr  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- wdata  in  NREQ*DATA_W  packed write data, same packing.
- gnt  out  NREQ  one-hot; high for the granted requester during ACCESS and ACK.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  read data shared by all requesters; valid when ack is high for a read.
- busy  out  1  high whenever the state is not IDLE.
- mem_address  out  ADDR_W  memory address.
- mem_ie  out  1  memory write enable; the memory writes on the falling clk edge while it is high.
- mem_oe  out  1  memory output enable; the memory drives the bus combinationally while it is high.
- mem_bus  inout  DATA_W  shared data bus; driven by this block only during write ACCESS, high-Z otherwise.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- **IDLE**
  - If any req bit is high, pick the winner by round-robin and go to ACCESS.
  - The search starts at last_grant+1 modulo NREQ.
  - On the same edge, register the winner's index, we, addr and wdata into the latched request.
  - Later changes on the requester inputs do not affect an access in flight.
- **ACCESS** (exactly 1 cycle)
  - mem_address = latched address.
  - Write: mem_ie=1, mem_bus=latched wdata, mem_oe=0.
  - Read: mem_oe=1, mem_ie=0, mem_bus released.
  - On the exit edge, capture rdata from mem_bus for reads; rdata is unchanged for writes. Go to ACK.
- **ACK** (exactly 1 cycle)
  - ack[winner]=1, mem_ie=mem_oe=0, bus released.
  - Update last_grant to the winner. Go to IDLE.
- **Invariants**
  - mem_ie and mem_oe are never high together.
  - The block never drives mem_bus while mem_oe=1.
  - gnt and ack are zero or one-hot.
- **Requester contract**
  - Hold req, we, addr and wdata stable from assertion until the edge after ack.
  - A req still high in the IDLE cycle after ack is treated as a new access.
- Requesters with req low are skipped; a lone requester wins immediately regardless of last_grant.
- mem_address holds its last value in IDLE and ACK, which avoids glitches on the memory's combinational read.

## Timing
- **Reset values**
  - state=IDLE; gnt=0, ack=0, busy=0, mem_ie=0, mem_oe=0, mem_address=0, rdata=0; mem_bus high-Z.
  - last_grant=NREQ-1, so requester 0 wins the first tie.
- **Reset mid-operation:** asserting rst_n low takes effect immediately and asynchronously.
  - Asserted in ACCESS before the falling edge: the write is suppressed, because mem_ie drops.
  - Asserted after the falling edge: the write has already landed.
  - No ack is issued for an aborted access. After release, the FSM resumes from IDLE.
- Latency is measured from the edge that samples req in IDLE (edge 0):
  - ACCESS runs between edges 0 and 1.
  - The memory write occurs at the falling edge inside ACCESS.
  - ack and rdata are valid between edges 1 and 2.
- Throughput is one access per 3 cycles; a pending request waits at most 3·(NREQ-1) cycles after the current access completes.
- Requests that are simultaneous in IDLE are resolved by round-robin only; no starvation is possible.

## Test plan
- Single read, bench memory initialised with data[i]=i: req[0]=1, we=0, addr=0x2A at edge 0 → mem_oe=1 with mem_address=0x2A in the next cycle. In the following cycle, ack=01 and rdata=0x2A. busy is high for exactly 2 cycles.
- Write then read-back: requester 1 writes 0xC3 to 0x10 → mem_ie=1 for 1 cycle, bus=0xC3, then ack=10. A subsequent read of 0x10 by requester 0 returns 0xC3.
- Contention: req=11 held continuously after reset → grants alternate 0,1,0,1. Each ack is spaced 3 cycles apart, and mem_ie·mem_oe is never 1.
- Held request: requester 0 keeps req high past ack with addr=0x05 → a second read of 0x05 starts in the next IDLE cycle and returns 0x05.
- Reset in ACCESS: assert rst_n low during a write ACCESS before the falling edge → memory location unchanged, no ack, all outputs return to reset values immediately.
- Bus discipline: across all scenarios, mem_bus is high-Z whenever the state is not a write ACCESS, and is driven by the block only when mem_oe=0.
